buffer_bank_pingpong: RTL and testbench

Parametrised ping-pong buffer for the memory bank. It holds two banks, and each bank has `N_PE` lanes of `DEPTH` words by `WID` bits. One bank is always the write bank (producer side) and the other is the read bank (consumer side), so reads and writes never collide. A four-phase swap handshake exchanges the two banks. Access is per lane in mode 0 (RAM-word view) and across all lanes in mode 1 (PE bus view).

---
 rtl/buffer_pkg.sv | 30 +++
 rtl/buffer_lane_ram.sv | 30 +++
 rtl/buffer_bank_pingpong.sv | 172 +++++++++++++++++
 tb/tb_buffer_bank_pingpong.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/buffer_pkg.sv
// Shared swap-state type, read latency and lane-select helper for the ping-pong buffer.
// BUFFER_RD_REG_EN selects the registered read path (LAT=2); otherwise LAT=1.
package buffer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DRAIN,
      ST_ACK
   } swap_state_t;

`ifdef BUFFER_RD_REG_EN
   localparam int unsigned LAT = 2;
`else
   localparam int unsigned LAT = 1;
`endif

   localparam int unsigned MAX_PE = 64;
   localparam int unsigned SEL_W  = $clog2(MAX_PE);

   // Index of the lowest set bit; 0 when no bit is set.
   function automatic logic [SEL_W-1:0] lowest_set(input logic [MAX_PE-1:0] v);
      logic [SEL_W-1:0] idx;
      idx = '0;
      for (int i = MAX_PE - 1; i >= 0; i--) begin
         if (v[i]) idx = SEL_W'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/buffer_lane_ram.sv
// One lane of DEPTH x WID storage: one write port, one synchronous read port.
// Only the read register is reset; the array contents are not.
module buffer_lane_ram #(
   parameter  int unsigned WID    = 8,
   parameter  int unsigned DEPTH  = 256,
   localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              w_en,
   input  logic [ADDR_W-1:0] w_addr,
   input  logic [WID-1:0]    w_data,
   input  logic              r_en,
   input  logic [ADDR_W-1:0] r_addr,
   output logic [WID-1:0]    r_data
);

   logic [WID-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (w_en) mem[w_addr] <= w_data;
   end

   // Read data holds between reads.
   always_ff @(posedge clk) begin
      if (rst)       r_data <= '0;
      else if (r_en) r_data <= mem[r_addr];
   end

endmodule

// File: rtl/buffer_bank_pingpong.sv
// Two-bank ping-pong buffer with per-lane (mode 0) and full-bus (mode 1) access and a swap handshake.
// BUFFER_RD_REG_EN adds an output register after the lane RAMs (LAT=2, two-cycle drain).
`ifndef N_PE
`define N_PE 4
`endif
`ifndef WID_RAM
`define WID_RAM 8
`endif

module buffer_bank_pingpong
   import buffer_pkg::*;
#(
   parameter  int unsigned N_PE   = `N_PE,
   parameter  int unsigned WID    = `WID_RAM,
   parameter  int unsigned DEPTH  = 256,
   localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                mode,
   input  logic [N_PE-1:0]     m0_w_en,
   input  logic [ADDR_W-1:0]   m0_w_addr,
   input  logic [WID-1:0]      m0_w_data,
   input  logic [N_PE-1:0]     m0_r_en,
   input  logic [ADDR_W-1:0]   m0_r_addr,
   output logic [WID-1:0]      m0_r_data,
   input  logic                m1_w_en,
   input  logic [ADDR_W-1:0]   m1_w_addr,
   input  logic [N_PE*WID-1:0] m1_w_data,
   input  logic                m1_r_en,
   input  logic [ADDR_W-1:0]   m1_r_addr,
   output logic [N_PE*WID-1:0] m1_r_data,
   output logic                r_valid,
   input  logic                swap_req,
   output logic                swap_ack,
   output logic                bank_sel,
   output logic                err_blocked,
   output logic                err_addr
);

   localparam int unsigned      LANE_W     = (N_PE > 1) ? $clog2(N_PE) : 1;
   localparam int unsigned      CNT_W      = 2;
   localparam logic [ADDR_W:0]  DEPTH_X    = (ADDR_W + 1)'(DEPTH);
   localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(LAT - 1);

   swap_state_t         state;
   logic [CNT_W-1:0]    drain_cnt;
   logic                idle, acc_w, acc_r, w_bad, r_bad, w_fire, r_fire;
   logic [ADDR_W-1:0]   w_addr, r_addr;
   logic [N_PE-1:0]     lane_w_en, lane_r_en;
   logic [WID-1:0]      lane_w_data [N_PE];
   logic [LANE_W-1:0]   r_lane, rd_lane_q;
   logic                rd_bank_q;
   logic [WID-1:0]      rd_data [2][N_PE];
   logic [WID-1:0]      m0_sel;
   logic [N_PE*WID-1:0] m1_sel;

   // Mode mux, address range check and per-lane enables.
   always_comb begin
      acc_w     = mode ? m1_w_en : (|m0_w_en);
      acc_r     = mode ? m1_r_en : (|m0_r_en);
      w_addr    = mode ? m1_w_addr : m0_w_addr;
      r_addr    = mode ? m1_r_addr : m0_r_addr;
      idle      = (state == ST_IDLE);
      w_bad     = acc_w && ({1'b0, w_addr} >= DEPTH_X);
      r_bad     = acc_r && ({1'b0, r_addr} >= DEPTH_X);
      w_fire    = idle && acc_w && !w_bad;
      r_fire    = idle && acc_r && !r_bad;
      r_lane    = LANE_W'(lowest_set(MAX_PE'(m0_r_en)));
      lane_w_en = '0;
      lane_r_en = '0;
      if (w_fire) lane_w_en = mode ? '1 : m0_w_en;
      if (r_fire) lane_r_en = mode ? '1 : (N_PE'(1) << r_lane);
      for (int k = 0; k < N_PE; k++) begin
         lane_w_data[k] = mode ? m1_w_data[k*WID +: WID] : m0_w_data;
      end
   end

   for (genvar b = 0; b < 2; b++) begin : g_bank
      for (genvar k = 0; k < N_PE; k++) begin : g_lane
         buffer_lane_ram #(.WID(WID), .DEPTH(DEPTH)) u_ram (
            .clk    (clk),
            .rst    (rst),
            .w_en   (lane_w_en[k] && (bank_sel == 1'(b))),
            .w_addr (w_addr),
            .w_data (lane_w_data[k]),
            .r_en   (lane_r_en[k] && (bank_sel != 1'(b))),
            .r_addr (r_addr),
            .r_data (rd_data[b][k])
         );
      end
   end

   for (genvar k = 0; k < N_PE; k++) begin : g_bus
      assign m1_sel[k*WID +: WID] = rd_data[rd_bank_q][k];
   end
   assign m0_sel = rd_data[rd_bank_q][rd_lane_q];

   // Swap FSM, error pulses and read-source tracking.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_IDLE;
         drain_cnt   <= '0;
         bank_sel    <= 1'b0;
         swap_ack    <= 1'b0;
         err_blocked <= 1'b0;
         err_addr    <= 1'b0;
         rd_bank_q   <= 1'b0;
         rd_lane_q   <= '0;
      end else begin
         err_blocked <= !idle && (acc_w || acc_r);
         err_addr    <= idle && (w_bad || r_bad);
         if (r_fire) rd_bank_q <= ~bank_sel;
         if (r_fire && !mode) rd_lane_q <= r_lane;
         case (state)
            ST_IDLE: begin
               if (swap_req) begin
                  state     <= ST_DRAIN;
                  drain_cnt <= '0;
               end
            end
            ST_DRAIN: begin
               if (drain_cnt == DRAIN_LAST) begin
                  state     <= ST_ACK;
                  drain_cnt <= '0;
                  bank_sel  <= ~bank_sel;
                  swap_ack  <= 1'b1;
               end else begin
                  drain_cnt <= drain_cnt + CNT_W'(1);
               end
            end
            ST_ACK: begin
               if (!swap_req) begin
                  state    <= ST_IDLE;
                  swap_ack <= 1'b0;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

`ifdef BUFFER_RD_REG_EN
   logic rd_v1;

   // Output register stage; data holds while no read completes.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_v1     <= 1'b0;
         r_valid   <= 1'b0;
         m0_r_data <= '0;
         m1_r_data <= '0;
      end else begin
         rd_v1   <= r_fire;
         r_valid <= rd_v1;
         if (rd_v1) begin
            m0_r_data <= m0_sel;
            m1_r_data <= m1_sel;
         end
      end
   end
`else
   always_ff @(posedge clk) begin
      if (rst) r_valid <= 1'b0;
      else     r_valid <= r_fire;
   end

   assign m0_r_data = m0_sel;
   assign m1_r_data = m1_sel;
`endif

endmodule

// File: tb/tb_buffer_bank_pingpong.sv
// Scoreboard bench for buffer_bank_pingpong: directed accesses, swaps, error pulses and reset abort.
module tb_buffer_bank_pingpong;
   import buffer_pkg::*;

   localparam int unsigned NP = 4;
   localparam int unsigned W  = 8;
   localparam int unsigned D  = 20;
   localparam int unsigned AW = 5;
   localparam int unsigned BW = NP * W;

   logic          clk, rst, mode;
   logic [NP-1:0] m0_w_en, m0_r_en;
   logic [AW-1:0] m0_w_addr, m0_r_addr, m1_w_addr, m1_r_addr;
   logic [W-1:0]  m0_w_data, m0_r_data;
   logic          m1_w_en, m1_r_en;
   logic [BW-1:0] m1_w_data, m1_r_data;
   logic          r_valid, swap_req, swap_ack, bank_sel, err_blocked, err_addr;

   buffer_bank_pingpong #(.N_PE(NP), .WID(W), .DEPTH(D)) dut (
      .clk(clk), .rst(rst), .mode(mode),
      .m0_w_en(m0_w_en), .m0_w_addr(m0_w_addr), .m0_w_data(m0_w_data),
      .m0_r_en(m0_r_en), .m0_r_addr(m0_r_addr), .m0_r_data(m0_r_data),
      .m1_w_en(m1_w_en), .m1_w_addr(m1_w_addr), .m1_w_data(m1_w_data),
      .m1_r_en(m1_r_en), .m1_r_addr(m1_r_addr), .m1_r_data(m1_r_data),
      .r_valid(r_valid), .swap_req(swap_req), .swap_ack(swap_ack),
      .bank_sel(bank_sel), .err_blocked(err_blocked), .err_addr(err_addr)
   );

   typedef struct packed {
      logic          wide;
      logic [BW-1:0] m1;
      logic [W-1:0]  m0;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   logic exp_bank;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #20000;
      $display("FAIL watchdog: simulation did not reach the end");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: every valid read pops the oldest expected response.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (r_valid === 1'b1) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_r_valid: got r_valid=1 expected 0");
            end else begin
               e = sb.pop_front();
               if (e.wide) chk("m1_r_data", m1_r_data, e.m1);
               else        chk("m0_r_data", 32'(m0_r_data), 32'(e.m0));
            end
         end
      end
   end

   task automatic wr1(input logic [AW-1:0] a, input logic [BW-1:0] d);
      mode = 1'b1; m1_w_en = 1'b1; m1_w_addr = a; m1_w_data = d;
      @(negedge clk);
      m1_w_en = 1'b0;
   endtask

   task automatic wr0(input logic [NP-1:0] en, input logic [AW-1:0] a, input logic [W-1:0] d);
      mode = 1'b0; m0_w_en = en; m0_w_addr = a; m0_w_data = d;
      @(negedge clk);
      m0_w_en = '0;
   endtask

   task automatic rd1(input logic [AW-1:0] a, input logic [BW-1:0] d);
      exp_t e;
      e.wide = 1'b1; e.m1 = d; e.m0 = '0;
      sb.push_back(e);
      mode = 1'b1; m1_r_en = 1'b1; m1_r_addr = a;
      @(negedge clk);
      m1_r_en = 1'b0;
   endtask

   task automatic rd0(input logic [NP-1:0] en, input logic [AW-1:0] a, input logic [W-1:0] d);
      exp_t e;
      e.wide = 1'b0; e.m1 = '0; e.m0 = d;
      sb.push_back(e);
      mode = 1'b0; m0_r_en = en; m0_r_addr = a;
      @(negedge clk);
      m0_r_en = '0;
   endtask

   task automatic flush();
      repeat (LAT + 1) @(negedge clk);
      chk("sb_drained", 32'(sb.size()), 32'd0);
   endtask

   // Full handshake with timing checks; tracks the expected bank.
   task automatic do_swap();
      swap_req = 1'b1;
      @(negedge clk);
      chk("drain_ack", 32'(swap_ack), 32'd0);
      chk("drain_bank", 32'(bank_sel), 32'(exp_bank));
      repeat (LAT - 1) begin
         @(negedge clk);
         chk("drain_ack", 32'(swap_ack), 32'd0);
      end
      @(negedge clk);
      exp_bank = ~exp_bank;
      chk("swap_bank", 32'(bank_sel), 32'(exp_bank));
      chk("swap_ack_hi", 32'(swap_ack), 32'd1);
      swap_req = 1'b0;
      @(negedge clk);
      chk("swap_ack_lo", 32'(swap_ack), 32'd0);
   endtask

   initial begin
      rst = 1'b1; mode = 1'b0; swap_req = 1'b0;
      m0_w_en = '0; m0_w_addr = '0; m0_w_data = '0; m0_r_en = '0; m0_r_addr = '0;
      m1_w_en = 1'b0; m1_w_addr = '0; m1_w_data = '0; m1_r_en = 1'b0; m1_r_addr = '0;
      exp_bank = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_bank_sel", 32'(bank_sel), 32'd0);
      chk("rst_swap_ack", 32'(swap_ack), 32'd0);
      chk("rst_r_valid", 32'(r_valid), 32'd0);
      chk("rst_m0_r_data", 32'(m0_r_data), 32'd0);
      chk("rst_m1_r_data", m1_r_data, 32'd0);
      chk("rst_err_blocked", 32'(err_blocked), 32'd0);
      chk("rst_err_addr", 32'(err_addr), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // Wide round trip: lane k holds k+1.
      wr1(5'd3, 32'h04030201);
      do_swap();
      rd1(5'd3, 32'h04030201);
      flush();

      // Narrow write into lanes 0 and 2 over a zeroed word.
      wr1(5'd5, 32'h00000000);
      wr0(4'b0101, 5'd5, 8'hAB);
      do_swap();
      rd1(5'd5, 32'h00AB00AB);
      rd0(4'b0001, 5'd5, 8'hAB);
      rd0(4'b0010, 5'd5, 8'h00);
      rd0(4'b0100, 5'd5, 8'hAB);
      rd0(4'b0110, 5'd5, 8'h00);
      flush();

      // Accesses during DRAIN and ACK are blocked.
      swap_req = 1'b1;
      @(negedge clk);
      mode = 1'b1; m1_w_en = 1'b1; m1_w_addr = 5'd3; m1_w_data = '1;
      m1_r_en = 1'b1; m1_r_addr = 5'd3;
      repeat (LAT + 1) begin
         @(negedge clk);
         chk("blocked_pulse", 32'(err_blocked), 32'd1);
      end
      exp_bank = ~exp_bank;
      chk("blocked_swap_bank", 32'(bank_sel), 32'(exp_bank));
      swap_req = 1'b0;
      @(negedge clk);
      chk("blocked_pulse_ack", 32'(err_blocked), 32'd1);
      chk("blocked_ack_lo", 32'(swap_ack), 32'd0);
      m1_w_en = 1'b0; m1_r_en = 1'b0;
      @(negedge clk);
      chk("blocked_clear", 32'(err_blocked), 32'd0);
      rd1(5'd3, 32'h04030201);
      flush();

      // Out-of-range address: dropped, single err_addr pulse, outputs hold.
      wr1(5'(D), 32'hFFFFFFFF);
      chk("oor_w_err", 32'(err_addr), 32'd1);
      @(negedge clk);
      chk("oor_w_err_end", 32'(err_addr), 32'd0);
      mode = 1'b1; m1_r_en = 1'b1; m1_r_addr = 5'(D);
      @(negedge clk);
      m1_r_en = 1'b0;
      chk("oor_r_err", 32'(err_addr), 32'd1);
      chk("oor_r_valid", 32'(r_valid), 32'd0);
      @(negedge clk);
      chk("oor_r_err_end", 32'(err_addr), 32'd0);
      chk("oor_r_valid_late", 32'(r_valid), 32'd0);
      chk("oor_hold", m1_r_data, 32'h04030201);
      wr0(4'b1111, 5'(D), 8'h55);
      chk("oor_m0_err", 32'(err_addr), 32'd1);
      rd1(5'd3, 32'h04030201);
      flush();
      do_swap();

      // Reset while in ACK aborts the swap.
      swap_req = 1'b1;
      repeat (LAT + 1) @(negedge clk);
      chk("pre_rst_ack", 32'(swap_ack), 32'd1);
      chk("pre_rst_bank", 32'(bank_sel), 32'd1);
      rst = 1'b1; swap_req = 1'b0;
      @(negedge clk);
      chk("abort_bank_sel", 32'(bank_sel), 32'd0);
      chk("abort_swap_ack", 32'(swap_ack), 32'd0);
      chk("abort_r_valid", 32'(r_valid), 32'd0);
      rst = 1'b0;
      exp_bank = 1'b0;
      @(negedge clk);
      wr1(5'd7, 32'hDEADBEEF);
      do_swap();
      rd1(5'd7, 32'hDEADBEEF);
      rd1(5'd3, 32'h04030201);
      flush();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
